pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h00000020, entry address for all non-eret exceptions.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, continuous-stall count that raises stall_timeout_o; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stallreq_from_id  input  1  decode stage requests stall.
REQ-006 stallreq_from_ex  input  1  execute stage requests stall (multi-cycle div/madd).
REQ-007 stallreq_from_mem  input  1  memory stage requests stall (bus wait).
REQ-008 excepttype_i  input  32  exception type from mem stage; 0 = none.
REQ-009 cp0_epc_i  input  32  current EPC from CP0.
REQ-010 stall  output  6  per-stage hold vector; bit0 = pc, bit5 = wb.
REQ-011 flush  output  1  pipeline flush pulse to pc_reg and all stage registers.
REQ-012 new_pc  output  32  redirect address, valid while flush=1.
REQ-013 stall_timeout_o  output  1  one-cycle pulse on continuous-stall timeout.
REQ-014 stall_cycles_o  output  32  saturating count of cycles with stall[0]=1 since reset.

Function
REQ-015 FSM SHALL have states RUN, FREEZE, FLUSH; encoding free.
REQ-016 RUN: excepttype_i != 0 SHALL move to FREEZE at the next edge, capturing target into new_pc register.
REQ-017 Target SHALL be cp0_epc_i when excepttype_i == 32'h0000000e (eret), else EXC_VECTOR, sampled in the same cycle as the RUN->FREEZE decision.
REQ-018 FREEZE: stall SHALL be 6'b111111, flush 0; unconditional transition to FLUSH.
REQ-019 FLUSH: flush SHALL be 1, stall 6'b000000, new_pc holds captured target; unconditional transition to RUN.
REQ-020 flush SHALL be high for exactly one cycle per accepted exception and derived from state only (registered, no combinational path from inputs).
REQ-021 excepttype_i SHALL be ignored in FREEZE and FLUSH; an exception still present in RUN after FLUSH SHALL be accepted as new.
REQ-022 RUN stall (combinational from requests), priority high to low: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; none -> 6'b000000.
REQ-023 In RUN, exception SHALL take priority over stall requests: stall 6'b000000 in the cycle excepttype_i != 0 is detected, stall requests ignored.
REQ-024 new_pc SHALL hold its last captured value outside FLUSH.
REQ-025 stall_cycles_o SHALL increment by 1 on each edge where stall[0]=1, saturating at 32'hFFFFFFFF without wrap.
REQ-026 Continuous-stall counter (16 bit) SHALL increment on each edge with stall[0]=1 in RUN, clear on any edge with stall[0]=0 or state != RUN.
REQ-027 stall_timeout_o SHALL pulse 1 cycle on the edge counter reaches TIMEOUT_CYCLES; counter then holds (no further pulses) until cleared.
REQ-028 FREEZE cycles SHALL count in stall_cycles_o but not in the continuous-stall counter.

Reset
REQ-029 rst=1 SHALL immediately force state RUN, flush 0, new_pc 32'h0, stall_cycles_o 0, continuous counter 0, stall_timeout_o 0.
REQ-030 stall SHALL be 6'b000000 during reset regardless of request inputs.
REQ-031 Reset asserted in FREEZE or FLUSH SHALL abort the sequence; no flush pulse after release.

Verification
REQ-032 stallreq_from_ex=1, others 0, RUN -> stall=6'b001111 same cycle; ex+mem both 1 -> 6'b011111.
REQ-033 excepttype_i=32'h00000008 one cycle -> next cycle stall=6'b111111; following cycle flush=1, new_pc=32'h00000020, stall=0; then flush=0.
REQ-034 excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234 -> flush=1 two cycles later with new_pc=32'h00001234.
REQ-035 excepttype_i=32'h0000000c held 4 cycles -> two flush pulses, 3 cycles apart (RUN-FREEZE-FLUSH-RUN-FREEZE-FLUSH).
REQ-036 TIMEOUT_CYCLES=4, stallreq_from_mem held 10 cycles -> single stall_timeout_o pulse at 4th stall edge; stall_cycles_o=10 after.
REQ-037 rst pulsed while in FREEZE -> flush stays 0, new_pc=0, state RUN; subsequent exception sequence behaves per REQ-033.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall vector, exception freeze/flush
// sequencing with redirect target, and stall accounting with a
// continuous-stall timeout pulse.
//
// Exception sequence: RUN --(excepttype_i != 0)--> FREEZE --> FLUSH --> RUN.
// FREEZE holds every stage for one cycle. FLUSH raises flush for exactly
// one cycle while new_pc carries the captured target.
//
// Handshake note: there is no valid/ready exchange here. Stall requests
// are level signals that are honoured in the same cycle. Exceptions are
// sampled only in RUN; a request that is still present when the FSM
// returns to RUN is accepted again as a new exception.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [31:0] ERET_CODE   = 32'h0000000e;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic        exc_take;
  logic [15:0] run_stall_cnt;

  // An exception is only accepted while running normally.
  assign exc_take = (state == RUN) && (excepttype_i != 32'h0);

  // Stall vector: forced low in reset, full hold in FREEZE, released in
  // FLUSH, and in RUN the deepest requesting stage wins unless an
  // exception is being taken this cycle.
  always_comb begin
    stall = 6'b000000;
    if (rst) begin
      stall = 6'b000000;
    end else begin
      case (state)
        FREEZE:  stall = 6'b111111;
        FLUSH:   stall = 6'b000000;
        default: begin
          if (exc_take)               stall = 6'b000000;
          else if (stallreq_from_mem) stall = 6'b011111;
          else if (stallreq_from_ex)  stall = 6'b001111;
          else if (stallreq_from_id)  stall = 6'b000111;
          else                        stall = 6'b000000;
        end
      endcase
    end
  end

  // Exception FSM with registered flush and captured redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      flush  <= 1'b0;
      new_pc <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          flush <= 1'b0;
          if (exc_take) begin
            state  <= FREEZE;
            new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
          end
        end
        FREEZE: begin
          state <= FLUSH;
          flush <= 1'b1;
        end
        FLUSH: begin
          state <= RUN;
          flush <= 1'b0;
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Total stalled-cycle count; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o <= 32'h0;
    end else if (stall[0] && (stall_cycles_o != 32'hFFFFFFFF)) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end

  // Continuous RUN-stall counter: pulses once on reaching the limit, then
  // holds until the stall breaks or the FSM leaves RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_stall_cnt   <= 16'h0;
      stall_timeout_o <= 1'b0;
    end else if ((state == RUN) && stall[0]) begin
      if (run_stall_cnt != TIMEOUT_LIM) begin
        run_stall_cnt   <= run_stall_cnt + 16'd1;
        stall_timeout_o <= ((run_stall_cnt + 16'd1) == TIMEOUT_LIM);
      end else begin
        stall_timeout_o <= 1'b0;
      end
    end else begin
      run_stall_cnt   <= 16'h0;
      stall_timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the pipeline
// controller's rules.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC     = 32'h00000020;
  localparam int          TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
  logic [31:0] exc = 32'h0, epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  int vectors = 0;
  int miscompares = 0;

  // Model: exception progress counted in cycles since acceptance
  // (-1 = none in flight; 1 = hold-all cycle; 2 = flush cycle).
  int          m_since;
  logic [31:0] m_pc;
  longint      m_total;
  int          m_run;
  logic        m_to;
  int          timeout_pulses;

  pipe_ctrl #(.EXC_VECTOR(VEC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(req_id), .stallreq_from_ex(req_ex),
    .stallreq_from_mem(req_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout_o(stall_timeout_o), .stall_cycles_o(stall_cycles_o)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [5:0] exp_stall();
    if (rst) return 6'b000000;
    if (m_since == 1) return 6'b111111;
    if (m_since == 2) return 6'b000000;
    if (exc != 0) return 6'b000000;
    if (req_mem) return 6'b011111;
    if (req_ex) return 6'b001111;
    if (req_id) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_since = -1;
    m_pc    = 32'h0;
    m_total = 0;
    m_run   = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    logic [5:0] s;
    bit         running;
    s = exp_stall();
    running = !(m_since == 1 || m_since == 2);
    if (s[0] && m_total < 64'hFFFFFFFF) m_total = m_total + 1;
    if (running && s[0]) begin
      if (m_run < TIMEOUT) begin
        m_run = m_run + 1;
        m_to  = (m_run == TIMEOUT);
      end else begin
        m_to = 1'b0;
      end
    end else begin
      m_run = 0;
      m_to  = 1'b0;
    end
    if (m_since == 1) m_since = 2;
    else if (m_since == 2) m_since = -1;
    else if (exc != 0) begin
      m_since = 1;
      m_pc    = (exc == 32'h0000000e) ? epc : VEC;
    end
  endtask

  task automatic check_all(input string tag);
    logic [5:0]  es;
    logic [31:0] ec;
    es = exp_stall();
    ec = m_total[31:0];
    vectors++;
    assert (stall === es) else begin
      miscompares++;
      $error("FAIL %s stall got %b exp %b", tag, stall, es);
    end
    vectors++;
    assert (flush === (m_since == 2)) else begin
      miscompares++;
      $error("FAIL %s flush got %b exp %b", tag, flush, (m_since == 2));
    end
    vectors++;
    assert (new_pc === m_pc) else begin
      miscompares++;
      $error("FAIL %s new_pc got %h exp %h", tag, new_pc, m_pc);
    end
    vectors++;
    assert (stall_timeout_o === m_to) else begin
      miscompares++;
      $error("FAIL %s timeout got %b exp %b", tag, stall_timeout_o, m_to);
    end
    vectors++;
    assert (stall_cycles_o === ec) else begin
      miscompares++;
      $error("FAIL %s stall_cycles got %0d exp %0d", tag, stall_cycles_o, ec);
    end
  endtask

  // driver
  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] e, input logic [31:0] pc);
    req_id = id; req_ex = ex; req_mem = mem; exc = e; epc = pc;
  endtask

  // One clock: check before the edge, then step the model with the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (stall_timeout_o === 1'b1) timeout_pulses++;
    model_edge();
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    timeout_pulses = 0;
    // reset with requests asserted: stall must stay clear
    drive(1, 1, 1, 32'h0, 32'h0);
    do_reset("reset");

    // stall priority
    drive(0, 1, 0, 32'h0, 32'h0);           cycle("ex_only");
    drive(0, 1, 1, 32'h0, 32'h0);           cycle("ex_mem");
    drive(1, 0, 0, 32'h0, 32'h0);           cycle("id_only");
    drive(0, 0, 0, 32'h0, 32'h0);           cycle("idle");

    // general exception, single cycle, with a stall request to ignore
    drive(0, 0, 1, 32'h00000008, 32'h0);    cycle("exc8_take");
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle("exc8_seq");

    // eret redirect
    drive(0, 0, 0, 32'h0000000e, 32'h00001234); cycle("eret_take");
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle("eret_seq");

    // exception held four cycles: two sequences back to back
    drive(0, 0, 0, 32'h0000000c, 32'h0);
    repeat (4) cycle("held_exc");
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle("held_tail");

    // continuous mem stall for the timeout check
    timeout_pulses = 0;
    drive(0, 0, 1, 32'h0, 32'h0);
    repeat (10) cycle("mem_hold");
    drive(0, 0, 0, 32'h0, 32'h0);
    cycle("mem_release");
    vectors++;
    assert (timeout_pulses == 1) else begin
      miscompares++;
      $error("FAIL timeout_count got %0d exp 1", timeout_pulses);
    end

    // reset during the hold-all cycle aborts the sequence
    do_reset("reset2");
    drive(0, 0, 0, 32'h00000008, 32'h0);    cycle("abort_take");
    drive(0, 0, 0, 32'h0, 32'h0);
    do_reset("abort_rst");
    repeat (3) cycle("abort_after");
    drive(0, 0, 0, 32'h00000008, 32'h0);    cycle("post_take");
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle("post_seq");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] e;
      case ($urandom_range(0, 9))
        0:       e = 32'h0000000e;
        1:       e = $urandom_range(1, 31);
        default: e = 32'h0;
      endcase
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), e, $urandom);
      if ($urandom_range(0, 5) == 0) begin
        drive(req_id, req_ex, 1'b1, 32'h0, epc);
        repeat ($urandom_range(3, 7)) cycle("rand_long");
      end else begin
        cycle("rand");
      end
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) cycle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
